// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: source end of the ucore configuration chain.
// Accepts config words over a valid/ready stream and shifts each one into
// the first ucore (cfg_en/cfg_out) one cycle after its handshake, counting
// words against a programmed length and reporting busy/done/err.
//
// Optional build macro: CFG_LOAD_TIMEOUT_EN
//    defined   -> a stall counter aborts the load (err=1) after
//                 TIMEOUT_CYCLES consecutive STREAM cycles without a handshake
//    undefined -> STREAM waits on s_valid indefinitely
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; start with num_words=0 just pulses done
// STREAM | accepting words; remaining >= 1 holds here
// FINISH | last word is being shifted (cfg_en=1); done follows next cycle
module cfg_chain_loader #(
   parameter int CFG_WIDTH      = 64,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] num_words,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [CFG_WIDTH-1:0] s_data,
   output logic                 cfg_en,
   output logic [CFG_WIDTH-1:0] cfg_out
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] remaining;
   logic                 hs;
   logic                 stall_limit;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("cfg_chain_loader: TIMEOUT_CYCLES must be >= 2");
   end

   // abort blocks the handshake in the same cycle so no word is half-taken
   assign s_ready = (state == STREAM) && !abort;
   assign hs      = s_valid && s_ready;
   assign busy    = (state != IDLE);

`ifdef CFG_LOAD_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES);

   logic [STALL_W-1:0] stall_cnt;

   assign stall_limit = (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

   // stall counter: held at zero outside STREAM, cleared by every handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if ((state != STREAM) || hs) begin
         stall_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`else
   assign stall_limit = 1'b0;
`endif

   // main sequencer: state, word count, chain shift and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         cfg_en    <= 1'b0;
         cfg_out   <= '0;
      end else begin
         done   <= 1'b0;
         cfg_en <= 1'b0;
         if (hs) begin
            cfg_en  <= 1'b1;
            cfg_out <= s_data;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  err <= 1'b0;
                  if (num_words == '0) begin
                     done <= 1'b1;
                  end else begin
                     remaining <= num_words;
                     state     <= STREAM;
                  end
               end
            end
            STREAM: begin
               // a handshake on the stall-limit cycle wins over the timeout
               if (abort || (!hs && stall_limit)) begin
                  state <= IDLE;
                  err   <= 1'b1;
               end else if (hs) begin
                  remaining <= remaining - 1'b1;
                  if (remaining == CNT_WIDTH'(1)) begin
                     state <= FINISH;
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
               done  <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
